// File: rtl/logic_unit_pkg.sv
// Shared types for the logical-operator arbiter slice.
// Opcode and FSM state encodings.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_LOR,
        OP_LAND,
        OP_LNOT,
        OP_BXOR
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/logic_alu.sv
// Combinational W-bit logical-operator unit.
// Logical ops return a single truth bit in bit 0.
module logic_alu
    import logic_unit_pkg::*;
#(
    parameter int W = 4
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_LOR:  y[0] = (|a) | (|b);
            OP_LAND: y[0] = (|a) & (|b);
            OP_LNOT: y[0] = ~(|a);
            OP_BXOR: y    = a ^ b;
            default: y    = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one logic_alu among N requesters,
// with a registered valid/ready response channel.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [2*N-1:0]       req_op,
    input  logic [W*N-1:0]       req_a,
    input  logic [W*N-1:0]       req_b,
    output logic [N-1:0]         gnt,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy
);

    localparam int IW = $clog2(N);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   id_q;
    logic            any;
    logic            grant;
    op_t             op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    alu_y;

    // Descending scan so the candidate closest to ptr is the last to win.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                win = IW'((int'(ptr) + k) % N);
            end
        end
    end

    assign grant = (state == S_IDLE) && any && !rst;

    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[win] = 1'b1;
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    logic_alu #(
        .W(W)
    ) u_alu (
        .op(op_q),
        .a (a_q),
        .b (b_q),
        .y (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            id_q     <= '0;
            op_q     <= OP_LOR;
            a_q      <= '0;
            b_q      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant) begin
                        op_q  <= op_t'(req_op[2*win +: 2]);
                        a_q   <= req_a[W*win +: W];
                        b_q   <= req_b[W*win +: W];
                        id_q  <= win;
                        ptr   <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data <= alu_y;
                    rsp_id   <= id_q;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized and directed bench for logic_unit_arbiter,
// checked against a behavioural round-robin model.
module tb_logic_unit_arbiter;
    import logic_unit_pkg::*;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_op;
    logic [W*N-1:0]  req_a;
    logic [W*N-1:0]  req_b;
    logic [N-1:0]    gnt;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;
    logic            rsp_ready;
    logic            busy;

    int passed = 0;
    int total  = 0;
    int mptr   = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    function automatic logic [W-1:0] model_alu(int op, logic [W-1:0] a,
                                               logic [W-1:0] b);
        case (op)
            0: return (a != 0 || b != 0) ? W'(1) : W'(0);
            1: return (a != 0 && b != 0) ? W'(1) : W'(0);
            2: return (a == 0) ? W'(1) : W'(0);
            default: return a ^ b;
        endcase
    endfunction

    function automatic int model_pick(logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    task automatic issue(input logic [N-1:0] r, input logic [2*N-1:0] o,
                         input logic [W*N-1:0] a, input logic [W*N-1:0] b,
                         output logic [N-1:0] g, output logic v1,
                         output logic v2, output logic [W-1:0] d,
                         output logic [IW-1:0] id);
        @(negedge clk);
        req = r; req_op = o; req_a = a; req_b = b; rsp_ready = 1'b1;
        #1 g = gnt;
        @(negedge clk);
        req = '0;
        v1 = rsp_valid;
        @(negedge clk);
        v2 = rsp_valid; d = rsp_data; id = rsp_id;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({gnt, rsp_valid, rsp_id, rsp_data, busy} !== '0)
            $display("FAIL reset_outputs got gnt=%b v=%b id=%0d d=%b busy=%b want all 0",
                     gnt, rsp_valid, rsp_id, rsp_data, busy);
        else passed++;
        rst = 1'b0;
        mptr = 0;
    endtask

    // Directed table: lane 0 only, exercises every opcode.
    task automatic test_opcodes();
        logic [1:0]   ops [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        logic [W-1:0] as  [6] = '{4'h0, 4'hF, 4'h1, 4'h0, 4'hA, 4'hA};
        logic [W-1:0] bs  [6] = '{4'h0, 4'h0, 4'h1, 4'h7, 4'h0, 4'h5};
        logic [W-1:0] ex  [6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'hF};
        logic [N-1:0] g;
        logic v1, v2;
        logic [W-1:0] d;
        logic [IW-1:0] id;
        for (int i = 0; i < 6; i++) begin
            issue(4'b0001, {6'h0, ops[i]}, {12'h0, as[i]}, {12'h0, bs[i]},
                  g, v1, v2, d, id);
            mptr = 1;
            total++;
            if (g !== 4'b0001 || v1 !== 1'b0 || v2 !== 1'b1)
                $display("FAIL op%0d_timing got gnt=%b v1=%b v2=%b want 0001 0 1",
                         i, g, v1, v2);
            else passed++;
            total++;
            if (d !== ex[i] || id !== 2'd0)
                $display("FAIL op%0d_data got d=%b id=%0d want d=%b id=0",
                         i, d, id, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] pats [2] = '{4'b1111, 4'b1001};
        int need [2] = '{5, 2};
        for (int p = 0; p < 2; p++) begin
            int got = 0;
            int cyc = 0;
            @(negedge clk);
            req = pats[p]; rsp_ready = 1'b1;
            while (got < need[p] && cyc < 40) begin
                #1;
                if (gnt != '0) begin
                    int w;
                    w = model_pick(pats[p]);
                    total++;
                    if (gnt !== N'(1 << w))
                        $display("FAIL fair%0d_grant%0d got %b want %b",
                                 p, got, gnt, N'(1 << w));
                    else passed++;
                    mptr = (w + 1) % N;
                    got++;
                end
                @(negedge clk);
                cyc++;
            end
            total++;
            if (got != need[p])
                $display("FAIL fair%0d_budget got %0d grants want %0d",
                         p, got, need[p]);
            else passed++;
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a0, b0, d0, ex;
        logic [IW-1:0] id0;
        int lane, w;
        lane = $urandom_range(N - 1);
        a0 = W'($urandom); b0 = W'($urandom);
        @(negedge clk);
        req = N'(1 << lane); req_op = '1;
        req_a = '0; req_b = '0;
        req_a[W*lane +: W] = a0; req_b[W*lane +: W] = b0;
        rsp_ready = 1'b0;
        w = model_pick(req);
        ex = model_alu(3, a0, b0);
        mptr = (w + 1) % N;
        @(negedge clk);
        req = '1;
        @(negedge clk);
        d0 = rsp_data; id0 = rsp_id;
        total++;
        if (rsp_valid !== 1'b1 || d0 !== ex || id0 !== IW'(lane))
            $display("FAIL bp_first got v=%b d=%b id=%0d want 1 %b %0d",
                     rsp_valid, d0, id0, ex, lane);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== id0 ||
                gnt !== '0 || busy !== 1'b1)
                $display("FAIL bp_hold%0d got v=%b d=%b id=%0d gnt=%b busy=%b",
                         c, rsp_valid, rsp_data, rsp_id, gnt, busy);
            else passed++;
        end
        req = '0; rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_release got v=%b busy=%b want 0 0",
                     rsp_valid, busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        logic v1, v2;
        logic [W-1:0] d;
        logic [IW-1:0] id;
        int seen = 0;
        @(negedge clk);
        req = 4'b0100; req_op = '1; req_a = '1; req_b = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req = '1; rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({gnt, rsp_valid, rsp_id, rsp_data, busy} !== '0)
            $display("FAIL rstmid_outputs got gnt=%b v=%b id=%0d d=%b busy=%b",
                     gnt, rsp_valid, rsp_id, rsp_data, busy);
        else passed++;
        rst = 1'b0; req = '0;
        mptr = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0)
            $display("FAIL rstmid_no_rsp got %0d valid cycles want 0", seen);
        else passed++;
        issue(4'b1111, '0, '0, '0, g, v1, v2, d, id);
        mptr = 1;
        total++;
        if (g !== 4'b0001 || v2 !== 1'b1 || id !== 2'd0)
            $display("FAIL rstmid_ptr got gnt=%b v=%b id=%0d want 0001 1 0",
                     g, v2, id);
        else passed++;
    endtask

    task automatic test_random();
        logic [N-1:0] r, g, eg;
        logic [2*N-1:0] o;
        logic [W*N-1:0] a, b;
        logic v1, v2;
        logic [W-1:0] d, ed;
        logic [IW-1:0] id;
        int w;
        for (int i = 0; i < 40; i++) begin
            r = N'($urandom); o = 8'($urandom);
            a = 16'($urandom); b = 16'($urandom);
            w = model_pick(r);
            eg = (w < 0) ? '0 : N'(1 << w);
            ed = (w < 0) ? '0 : model_alu(int'(o[2*w +: 2]),
                                          a[W*w +: W], b[W*w +: W]);
            issue(r, o, a, b, g, v1, v2, d, id);
            total++;
            if (g !== eg || v1 !== 1'b0 || v2 !== (w >= 0))
                $display("FAIL rnd%0d_ctl req=%b got gnt=%b v1=%b v2=%b want gnt=%b",
                         i, r, g, v1, v2, eg);
            else passed++;
            if (w >= 0) begin
                total++;
                if (d !== ed || id !== IW'(w))
                    $display("FAIL rnd%0d_data got d=%b id=%0d want d=%b id=%0d",
                             i, d, id, ed, w);
                else passed++;
                mptr = (w + 1) % N;
            end
        end
    endtask

    initial begin
        test_reset();
        test_opcodes();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
